// File: rtl/calc_key_sequencer_if.sv
// Key-entry and calculator bus for calc_key_sequencer.
// Ports:
//   key_valid/key_cmd/key_val/key_ready : key event handshake
//   a/b/op/result                       : operands, opcode and combinational result
//   res_out/res_valid/neg               : registered result for display logic
//   err/err_code/state_o                : error status and debug state
// slave  = sequencer side, master = environment side (keys + calculator result).
interface calc_key_sequencer_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned RESW = 8
);
  logic            key_valid;
  logic [1:0]      key_cmd;
  logic [3:0]      key_val;
  logic            key_ready;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic [1:0]      op;
  logic [RESW-1:0] result;
  logic [RESW-1:0] res_out;
  logic            res_valid;
  logic            neg;
  logic            err;
  logic [1:0]      err_code;
  logic [2:0]      state_o;

  modport slave (
    input  key_valid, key_cmd, key_val, result,
    output key_ready, a, b, op, res_out, res_valid, neg, err, err_code, state_o
  );

  modport master (
    output key_valid, key_cmd, key_val, result,
    input  key_ready, a, b, op, res_out, res_valid, neg, err, err_code, state_o
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Sequential key front end for the 4-bit calculator: builds decimal operands A/B
// and the opcode from key events, drives the calculator and captures its result.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : calc_key_sequencer_if.slave (key handshake, calculator a/b/op/result,
//          registered res_out/res_valid/neg, err/err_code, state_o debug)
module calc_key_sequencer #(
  parameter int unsigned OPW   = 4,
  parameter int unsigned RESW  = 8,
  parameter int unsigned RADIX = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_key_sequencer_if.slave   bus
);

  // Accumulator wide enough for cur*RADIX + d with cur < 2^OPW and RADIX, d <= 16.
  localparam int unsigned ACCW = OPW + 5;
  localparam logic [ACCW-1:0] ACC_MAX = ACCW'((1 << OPW) - 1);
  localparam logic [RESW-1:0] RES_MAX = RESW'((1 << OPW) - 1);
  localparam logic [4:0]      RADIX_L = 5'(RADIX);

  localparam logic [1:0] CMD_DIGIT  = 2'b00;
  localparam logic [1:0] CMD_OP     = 2'b01;
  localparam logic [1:0] CMD_EQUALS = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EVAL    = 3'd2,
    SHOW    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t          state;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [1:0]      op_q;
  logic [RESW-1:0] res_q;
  logic            res_valid_q;
  logic            neg_q;
  logic            err_q;
  logic [1:0]      err_code_q;
  logic            key_ready_q;

  logic [OPW-1:0]  acc_cur;
  logic [ACCW-1:0] acc_next;
  logic            digit_ok;
  logic            acc_ovf;
  logic            do_clear;

  // Decimal accumulation into whichever operand is being entered.
  always_comb begin
    acc_cur  = (state == ENTER_B) ? b_q : a_q;
    acc_next = ACCW'(acc_cur) * ACCW'(RADIX) + ACCW'(bus.key_val);
    acc_ovf  = (acc_next > ACC_MAX);
    digit_ok = ({1'b0, bus.key_val} < RADIX_L);
    do_clear = bus.key_valid && (bus.key_cmd == CMD_CLEAR);
  end

  // Sequencer FSM; CLEAR shares the reset path and overrides every transition.
  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      state       <= ENTER_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      key_ready_q <= 1'b1;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        ENTER_A: begin
          if (bus.key_valid) begin
            if (bus.key_cmd == CMD_DIGIT && digit_ok) begin
              if (acc_ovf) begin
                state      <= ERROR;
                err_q      <= 1'b1;
                err_code_q <= ERR_OVF;
              end else begin
                a_q <= OPW'(acc_next);
              end
            end else if (bus.key_cmd == CMD_OP) begin
              op_q  <= bus.key_val[1:0];
              b_q   <= '0;
              state <= ENTER_B;
            end
          end
        end

        ENTER_B: begin
          if (bus.key_valid) begin
            if (bus.key_cmd == CMD_DIGIT && digit_ok) begin
              if (acc_ovf) begin
                state      <= ERROR;
                err_q      <= 1'b1;
                err_code_q <= ERR_OVF;
              end else begin
                b_q <= OPW'(acc_next);
              end
            end else if (bus.key_cmd == CMD_OP) begin
              op_q <= bus.key_val[1:0];
            end else if (bus.key_cmd == CMD_EQUALS) begin
              // Divide by zero is caught here so the calculator never sees it.
              if (op_q == OP_DIV && b_q == '0) begin
                state      <= ERROR;
                err_q      <= 1'b1;
                err_code_q <= ERR_DIV0;
              end else begin
                state       <= EVAL;
                key_ready_q <= 1'b0;
              end
            end
          end
        end

        // Single evaluation cycle: a/b/op are stable, capture the result.
        EVAL: begin
          res_q       <= bus.result;
          neg_q       <= (op_q == OP_SUB) && (a_q < b_q);
          res_valid_q <= 1'b1;
          key_ready_q <= 1'b1;
          state       <= SHOW;
        end

        SHOW: begin
          if (bus.key_valid) begin
            if (bus.key_cmd == CMD_DIGIT && digit_ok) begin
              a_q   <= OPW'(bus.key_val);
              b_q   <= '0;
              state <= ENTER_A;
            end else if (bus.key_cmd == CMD_OP) begin
              // Chaining only when the previous result fits an operand.
              if (res_q <= RES_MAX && !neg_q) begin
                a_q   <= OPW'(res_q);
                op_q  <= bus.key_val[1:0];
                b_q   <= '0;
                state <= ENTER_B;
              end else begin
                state      <= ERROR;
                err_q      <= 1'b1;
                err_code_q <= ERR_OVF;
              end
            end
          end
        end

        ERROR: begin
          err_q <= 1'b1;
        end

        default: begin
          state <= ENTER_A;
        end
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.res_out   = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.key_ready = key_ready_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed self-checking bench for calc_key_sequencer with a behavioural
// 4-bit calculator closing the a/b/op -> result loop.
module tb_calc_key_sequencer;

  localparam logic [1:0] DIG = 2'b00;
  localparam logic [1:0] OPK = 2'b01;
  localparam logic [1:0] EQ  = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  calc_key_sequencer_if #(.OPW(4), .RESW(8)) bus_if ();

  calc_key_sequencer #(.OPW(4), .RESW(8), .RADIX(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream calculator model.
  always_comb begin
    case (bus_if.op)
      2'b00:   bus_if.result = 8'(bus_if.a) + 8'(bus_if.b);
      2'b01:   bus_if.result = 8'(bus_if.a) - 8'(bus_if.b);
      2'b10:   bus_if.result = 8'(bus_if.a) * 8'(bus_if.b);
      default: bus_if.result = (bus_if.b == 4'd0) ? 8'hFF : 8'(bus_if.a) / 8'(bus_if.b);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one key for one clock edge; called and returns at a negedge.
  task automatic key(input logic [1:0] cmd, input logic [3:0] val);
    bus_if.key_valid = 1'b1;
    bus_if.key_cmd   = cmd;
    bus_if.key_val   = val;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
    bus_if.key_cmd   = DIG;
    bus_if.key_val   = 4'd0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    bus_if.key_valid = 1'b0;
    bus_if.key_cmd   = DIG;
    bus_if.key_val   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(bus_if.state_o), 0);
    chk("rst_a", 32'(bus_if.a), 0);
    chk("rst_b", 32'(bus_if.b), 0);
    chk("rst_op", 32'(bus_if.op), 0);
    chk("rst_res", 32'(bus_if.res_out), 0);
    chk("rst_rv", 32'(bus_if.res_valid), 0);
    chk("rst_neg", 32'(bus_if.neg), 0);
    chk("rst_err", 32'(bus_if.err), 0);
    chk("rst_ecode", 32'(bus_if.err_code), 0);
    chk("rst_ready", 32'(bus_if.key_ready), 1);

    // 1: 12 + 3
    key(DIG, 4'd1);  chk("t1_a1", 32'(bus_if.a), 1);
    key(DIG, 4'd2);  chk("t1_a12", 32'(bus_if.a), 12);
    key(OPK, 4'd0);  chk("t1_stB", 32'(bus_if.state_o), 1);
    key(DIG, 4'd3);  chk("t1_b3", 32'(bus_if.b), 3);
    key(EQ, 4'd0);
    chk("t1_eval", 32'(bus_if.state_o), 2);
    chk("t1_ready0", 32'(bus_if.key_ready), 0);
    chk("t1_rv_eval", 32'(bus_if.res_valid), 0);
    chk("t1_op", 32'(bus_if.op), 0);
    tick();
    chk("t1_show", 32'(bus_if.state_o), 3);
    chk("t1_res", 32'(bus_if.res_out), 15);
    chk("t1_rv1", 32'(bus_if.res_valid), 1);
    chk("t1_neg", 32'(bus_if.neg), 0);
    chk("t1_ready1", 32'(bus_if.key_ready), 1);
    tick();
    chk("t1_rv_low", 32'(bus_if.res_valid), 0);
    chk("t1_res_hold", 32'(bus_if.res_out), 15);

    // 2: operand overflow, then digit ignored in ERROR, then CLEAR
    key(CLR, 4'd0);  chk("t2_clr_res", 32'(bus_if.res_out), 0);
    key(DIG, 4'd1);
    key(DIG, 4'd6);
    chk("t2_err", 32'(bus_if.err), 1);
    chk("t2_ecode", 32'(bus_if.err_code), 1);
    chk("t2_state", 32'(bus_if.state_o), 4);
    key(DIG, 4'd2);
    chk("t2_stay", 32'(bus_if.state_o), 4);
    chk("t2_ecode_hold", 32'(bus_if.err_code), 1);
    key(CLR, 4'd0);
    chk("t2_clr_state", 32'(bus_if.state_o), 0);
    chk("t2_clr_a", 32'(bus_if.a), 0);
    chk("t2_clr_b", 32'(bus_if.b), 0);
    chk("t2_clr_op", 32'(bus_if.op), 0);
    chk("t2_clr_err", 32'(bus_if.err), 0);
    chk("t2_clr_ecode", 32'(bus_if.err_code), 0);

    // Boundary: 15 fits exactly
    key(DIG, 4'd1);
    key(DIG, 4'd5);
    chk("bnd_a15", 32'(bus_if.a), 15);
    chk("bnd_state", 32'(bus_if.state_o), 0);
    key(CLR, 4'd0);

    // 3: divide by zero, then 6/3
    key(DIG, 4'd6);
    key(OPK, 4'd3);
    key(DIG, 4'd0);
    key(EQ, 4'd0);
    chk("t3_state", 32'(bus_if.state_o), 4);
    chk("t3_ecode", 32'(bus_if.err_code), 2);
    chk("t3_rv", 32'(bus_if.res_valid), 0);
    tick();
    chk("t3_rv2", 32'(bus_if.res_valid), 0);
    chk("t3_state2", 32'(bus_if.state_o), 4);
    key(CLR, 4'd0);
    key(DIG, 4'd6);
    key(OPK, 4'd3);
    key(DIG, 4'd3);
    key(EQ, 4'd0);
    tick();
    chk("t3_res", 32'(bus_if.res_out), 2);
    chk("t3_rv1", 32'(bus_if.res_valid), 1);

    // 4: 3 - 5 underflow, then chaining refused
    key(CLR, 4'd0);
    key(DIG, 4'd3);
    key(OPK, 4'd1);
    key(DIG, 4'd5);
    key(EQ, 4'd0);
    tick();
    chk("t4_res", 32'(bus_if.res_out), 32'h0000_00FE);
    chk("t4_neg", 32'(bus_if.neg), 1);
    key(OPK, 4'd0);
    chk("t4_state", 32'(bus_if.state_o), 4);
    chk("t4_ecode", 32'(bus_if.err_code), 1);
    chk("t4_res_keep", 32'(bus_if.res_out), 32'h0000_00FE);

    // 5: chaining 5*3=15, 15+2=17, then refused
    key(CLR, 4'd0);
    key(DIG, 4'd5);
    key(OPK, 4'd2);
    key(DIG, 4'd3);
    key(EQ, 4'd0);
    tick();
    chk("t5_res15", 32'(bus_if.res_out), 15);
    key(OPK, 4'd0);
    chk("t5_chain_state", 32'(bus_if.state_o), 1);
    chk("t5_chain_a", 32'(bus_if.a), 15);
    chk("t5_chain_op", 32'(bus_if.op), 0);
    chk("t5_chain_b", 32'(bus_if.b), 0);
    key(DIG, 4'd2);
    key(EQ, 4'd0);
    tick();
    chk("t5_res17", 32'(bus_if.res_out), 17);
    chk("t5_neg", 32'(bus_if.neg), 0);
    key(OPK, 4'd1);
    chk("t5_state", 32'(bus_if.state_o), 4);
    chk("t5_ecode", 32'(bus_if.err_code), 1);

    // 6a: rst in ENTER_B with a=7
    key(CLR, 4'd0);
    key(DIG, 4'd7);
    key(OPK, 4'd2);
    chk("t6_pre_a", 32'(bus_if.a), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_state", 32'(bus_if.state_o), 0);
    chk("t6_rst_a", 32'(bus_if.a), 0);
    chk("t6_rst_op", 32'(bus_if.op), 0);
    chk("t6_rst_rv", 32'(bus_if.res_valid), 0);
    chk("t6_rst_ready", 32'(bus_if.key_ready), 1);

    // 6b: CLEAR during EVAL
    key(DIG, 4'd2);
    key(OPK, 4'd0);
    key(DIG, 4'd3);
    key(EQ, 4'd0);
    chk("t6_eval", 32'(bus_if.state_o), 2);
    key(CLR, 4'd0);
    chk("t6_clr_state", 32'(bus_if.state_o), 0);
    chk("t6_clr_rv", 32'(bus_if.res_valid), 0);
    tick();
    chk("t6_clr_rv2", 32'(bus_if.res_valid), 0);
    chk("t6_clr_res", 32'(bus_if.res_out), 0);

    // 6c: digit >= RADIX ignored
    key(DIG, 4'd4);
    key(DIG, 4'd12);
    chk("t6_dig12_a", 32'(bus_if.a), 4);
    chk("t6_dig12_state", 32'(bus_if.state_o), 0);

    // 6d: digit during EVAL dropped
    key(OPK, 4'd0);
    key(DIG, 4'd5);
    key(EQ, 4'd0);
    chk("t6_eval_ready", 32'(bus_if.key_ready), 0);
    key(DIG, 4'd4);
    chk("t6_drop_state", 32'(bus_if.state_o), 3);
    chk("t6_drop_res", 32'(bus_if.res_out), 9);
    chk("t6_drop_rv", 32'(bus_if.res_valid), 1);
    chk("t6_drop_a", 32'(bus_if.a), 4);
    chk("t6_drop_b", 32'(bus_if.b), 5);

    // SHOW + DIGIT starts a new calculation
    key(DIG, 4'd7);
    chk("show_dig_state", 32'(bus_if.state_o), 0);
    chk("show_dig_a", 32'(bus_if.a), 7);
    chk("show_dig_b", 32'(bus_if.b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
